qif_spike_monitor: RTL and testbench
====================================

QIF_SPIKE_MONITOR -- requirements
Module: qif_spike_monitor

Downstream stage of the QIF neuron. Consumes its spike output, counts spikes per fixed window, measures inter-spike interval (ISI), and streams a per-window report over a byte valid/ready interface.

Interface
REQ-001 Parameter WINDOW, default 1024: window length in enabled clk cycles, legal range 2..65536.
REQ-002 clk  input  1  single clock; all state rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  block enable; high = counting active.
REQ-005 spike_in  input  1  neuron spike level; each 0->1 transition is one spike event.
REQ-006 out_data  output  8  report byte.
REQ-007 out_valid  output  1  out_data holds a valid byte.
REQ-008 out_ready  input  1  consumer accepts byte when high with out_valid.
REQ-009 overflow  output  1  sticky flag: a window report was dropped.

Function
REQ-010 The block SHALL register spike_in once; spike event = spike_in high AND registered copy low AND ena high.
REQ-011 The window counter SHALL count 0..WINDOW-1 on each ena-high cycle, wrap to 0, and assert window-end on the cycle it holds WINDOW-1.
REQ-012 The spike counter SHALL be 8 bits, increment per spike event, saturate at 255, and clear to 0 on window-end.
REQ-013 A spike event on the window-end cycle SHALL be counted in the ending window, i.e. included in its snapshot.
REQ-014 The ISI counter SHALL be 16 bits, increment per ena-high cycle, and saturate at 0xFFFF.
REQ-015 On a spike event, last_isi SHALL load ISI counter + 1, saturating at 0xFFFF, and the ISI counter SHALL clear to 0.
REQ-016 last_isi SHALL be 0 until the first spike event after reset.
REQ-017 With ena low, the window, spike and ISI counters SHALL hold, and spike events SHALL be ignored.
REQ-018 The output FSM SHALL drain regardless of ena.
REQ-019 On window-end with the FSM in IDLE, the block SHALL snapshot {count, last_isi} (last_isi including any same-cycle update) and move to SEND_CNT on the next cycle.
REQ-020 FSM states and bytes: IDLE; SEND_CNT (count); SEND_HI (last_isi[15:8]); SEND_LO (last_isi[7:0]); then back to IDLE.
REQ-021 Each SEND state SHALL advance only on a cycle with out_valid AND out_ready high.
REQ-022 out_valid SHALL be high in every SEND state and low in IDLE.
REQ-023 out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-024 out_data SHALL be 0 in IDLE.
REQ-025 On window-end with the FSM not in IDLE, the new snapshot SHALL be discarded and overflow SHALL be set.
REQ-026 On window-end in the same cycle SEND_LO completes, the FSM is not in IDLE, so REQ-025 applies.
REQ-027 Latency: the first report byte SHALL be valid 1 cycle after the window-end cycle.

Reset
REQ-028 rst_n low SHALL asynchronously clear all counters, last_isi, snapshot and overflow, and force the FSM to IDLE.
REQ-029 While rst_n is low: out_valid=0, out_data=0x00, overflow=0.
REQ-030 A reset asserted mid-report SHALL abandon the report; no partial byte SHALL appear after reset release.
REQ-031 The first window after reset release SHALL start at window count 0.

Configuration
REQ-032 Macro QIF_MON_ISI_EN defined: ISI logic present; report is 3 bytes (REQ-020).
REQ-033 Macro QIF_MON_ISI_EN undefined: ISI counter and last_isi omitted; report is the count byte only; SEND_CNT returns to IDLE; all other behaviour unchanged.

Verification (WINDOW=16, QIF_MON_ISI_EN defined unless stated)
REQ-034 Bench: ena=1, out_ready=1, spike edges detected at cycles 3 and 8 of window 0 -> bytes 0x02, 0x00, 0x05, first byte 1 cycle after window-end.
REQ-035 Bench: 300 spike edges within one window (WINDOW=1024) -> count byte 0xFF.
REQ-036 Bench: out_ready=0 for 40 cycles after first valid -> out_data held at count byte; overflow=1 after next window-end; report resumes unchanged when out_ready=1.
REQ-037 Bench: spike edge on window-end cycle (count 15) -> included in that report; next window report count=0 if no further spikes.
REQ-038 Bench: rst_n pulsed low during SEND_HI -> out_valid=0 immediately; next report appears only after 16 enabled cycles.
REQ-039 Bench: QIF_MON_ISI_EN undefined, 3 spikes in window -> single byte 0x03, then IDLE.

Source files
------------

// File: rtl/qif_spike_monitor.sv
// Spike-rate and inter-spike-interval monitor that sits behind the QIF neuron and streams per-window reports.
// Optional ISI measurement and its two extra report bytes are built when QIF_MON_ISI_EN is defined.
module qif_spike_monitor #(
  parameter int WINDOW = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       spike_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_CNT = 2'd1,
    SEND_HI  = 2'd2,
    SEND_LO  = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  logic             spike_q;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       spike_cnt;
  logic [7:0]       cnt_next;
  logic             spike_evt;
  logic             win_end;
  logic             handshake;
  state_t           state;

  always_comb begin
    spike_evt = ena & spike_in & ~spike_q;
    win_end   = ena && (win_cnt == WIN_LAST);
    cnt_next  = spike_evt ? sat_inc8(spike_cnt) : spike_cnt;
    handshake = out_valid & out_ready;
  end

  // The edge detector runs even while disabled, so a level already high at re-enable is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q   <= 1'b0;
      win_cnt   <= '0;
      spike_cnt <= 8'd0;
    end else begin
      spike_q <= spike_in;
      if (ena) begin
        win_cnt   <= win_end ? '0 : win_cnt + 1'b1;
        spike_cnt <= win_end ? 8'd0 : cnt_next;
      end
    end
  end

`ifdef QIF_MON_ISI_EN
  logic [15:0] isi_cnt;
  logic [15:0] last_isi;
  logic [15:0] last_isi_next;
  logic [15:0] snap_isi;

  always_comb begin
    last_isi_next = spike_evt ? sat_inc16(isi_cnt) : last_isi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt  <= 16'd0;
      last_isi <= 16'd0;
    end else if (ena) begin
      isi_cnt  <= spike_evt ? 16'd0 : sat_inc16(isi_cnt);
      last_isi <= last_isi_next;
    end
  end
`endif

  // Report FSM: out_data/out_valid are registered and only change on a handshake or a fresh snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      overflow  <= 1'b0;
`ifdef QIF_MON_ISI_EN
      snap_isi  <= 16'd0;
`endif
    end else begin
      if (win_end && (state != IDLE)) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (win_end) begin
            state     <= SEND_CNT;
            out_valid <= 1'b1;
            out_data  <= cnt_next;
`ifdef QIF_MON_ISI_EN
            snap_isi  <= last_isi_next;
`endif
          end
        end
        SEND_CNT: begin
          if (handshake) begin
`ifdef QIF_MON_ISI_EN
            state    <= SEND_HI;
            out_data <= snap_isi[15:8];
`else
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
`endif
          end
        end
`ifdef QIF_MON_ISI_EN
        SEND_HI: begin
          if (handshake) begin
            state    <= SEND_LO;
            out_data <= snap_isi[7:0];
          end
        end
        SEND_LO: begin
          if (handshake) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qif_spike_monitor.sv
// Bench for qif_spike_monitor: a WINDOW=16 instance with a reference scoreboard plus directed checks,
// and a WINDOW=1024 instance for count saturation. Adapts to QIF_MON_ISI_EN.
module tb_qif_spike_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overflow;

  logic       rst_b_n = 1'b0;
  logic       spike_b = 1'b0;
  logic [7:0] out_data_b;
  logic       out_valid_b;
  logic       overflow_b;
  logic       big_done = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  int exp_q[$];
  int got[$];
  int m_win, m_cnt, m_isi, m_last;
  bit m_prev, m_ovf;

  always #5 clk = ~clk;

  qif_spike_monitor #(.WINDOW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  qif_spike_monitor #(.WINDOW(1024)) u_big (
    .clk(clk), .rst_n(rst_b_n), .ena(1'b1), .spike_in(spike_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(1'b1), .overflow(overflow_b)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string tag, input int b0, input int b1, input int b2);
`ifdef QIF_MON_ISI_EN
    check({tag, "_len"}, got.size(), 3);
    if (got.size() == 3) begin
      check({tag, "_b0"}, got[0], b0);
      check({tag, "_b1"}, got[1], b1);
      check({tag, "_b2"}, got[2], b2);
    end
`else
    check({tag, "_len"}, got.size(), 1);
    if (got.size() == 1) check({tag, "_b0"}, got[0], b0);
`endif
    got.delete();
  endtask

  // Scoreboard: checks outputs each cycle, then predicts the effect of the coming rising edge.
  always @(negedge clk) begin
    bit idle, ev;
    int cnt_n, last_n;
    if (!rst_n) begin
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_ovf", overflow, 0);
      m_win = 0; m_cnt = 0; m_isi = 0; m_last = 0; m_prev = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      idle = (exp_q.size() == 0);
      check("sb_valid", out_valid, idle ? 0 : 1);
      check("sb_data", out_data, idle ? 0 : exp_q[0]);
      check("sb_ovf", overflow, m_ovf);
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (!idle && out_ready) void'(exp_q.pop_front());
      ev = spike_in && !m_prev && ena;
      m_prev = spike_in;
      if (ena) begin
        cnt_n  = (ev && m_cnt != 255) ? m_cnt + 1 : m_cnt;
        last_n = ev ? ((m_isi == 65535) ? 65535 : m_isi + 1) : m_last;
        if (m_win == 15) begin
          if (idle) begin
            exp_q.push_back(cnt_n);
`ifdef QIF_MON_ISI_EN
            exp_q.push_back((last_n >> 8) & 255);
            exp_q.push_back(last_n & 255);
`endif
          end else begin
            m_ovf = 1;
          end
          m_cnt = 0;
          m_win = 0;
        end else begin
          m_cnt = cnt_n;
          m_win = m_win + 1;
        end
        m_isi  = ev ? 0 : ((m_isi == 65535) ? 65535 : m_isi + 1);
        m_last = last_n;
      end
    end
  end

  // Saturation: 300 spike edges inside one 1024-cycle window.
  initial begin
    int n;
    repeat (2) tick();
    rst_b_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      spike_b = i[0];
      tick();
    end
    spike_b = 1'b0;
    n = 0;
    while (!out_valid_b && n < 1000) begin
      tick();
      n++;
    end
    check("big_valid", out_valid_b, 1);
    check("big_count", out_data_b, 8'hFF);
    big_done = 1'b1;
  end

  initial begin
    int n;
    ena = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_ovf", overflow, 0);
    rst_n = 1'b1;

    // Window 0: spikes at cycles 3 and 8.
    for (int c = 0; c < 16; c++) begin
      spike_in = (c == 3 || c == 8);
      check("pre_end_valid", out_valid, 0);
      tick();
    end
    check("latency_valid", out_valid, 1);
    check("latency_data", out_data, 8'h02);

    // Window 1: spike only on the window-end cycle.
    for (int c = 0; c < 16; c++) begin
      spike_in = (c == 15);
      tick();
    end
    check_got("w0_report", 8'h02, 8'h00, 8'h05);

    // Window 2: no counted spikes; edges while disabled must be ignored.
    for (int c = 0; c < 16; c++) begin
      if (c == 5) begin
        for (int k = 0; k < 6; k++) begin
          ena = 1'b0;
          spike_in = k[0];
          tick();
        end
        ena = 1'b1;
      end
      spike_in = 1'b0;
      tick();
    end
    check_got("w1_edge_spike", 8'h01, 8'h00, 8'h17);

    // Window 3: three spikes, consumer stalls from the last cycle on.
    for (int c = 0; c < 16; c++) begin
      spike_in = (c == 2 || c == 6 || c == 10);
      if (c == 15) out_ready = 1'b0;
      tick();
    end
    check_got("w2_empty", 8'h00, 8'h00, 8'h17);

    repeat (40) tick();
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 8'h03);
    check("stall_ovf", overflow, 1);
    out_ready = 1'b1;
    repeat (4) tick();
    check_got("w3_resumed", 8'h03, 8'h00, 8'h04);
    check("after_report_idle", out_valid, 0);

    // Reset in the middle of a report.
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("rpt_wait", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`ifdef QIF_MON_ISI_EN
    check("send_hi_valid", out_valid, 1);
`endif
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_ovf", overflow, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    check("post_rst_valid", out_valid, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("post_rst_latency", n, 16);
    check("post_rst_nopartial", got.size(), 0);
    repeat (4) tick();

    n = 0;
    while (!big_done && n < 3000) begin
      tick();
      n++;
    end
    check("big_done", big_done, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
